// File: rtl/spi_frame_sequencer.sv
// SPI frame sequencer: frames up to DEPTH TX bytes under one SS_N assertion and captures the MISO bytes.
// Optional echo checking is enabled by defining SPI_SEQ_ECHO_CHECK_EN.
module spi_frame_sequencer #(
  parameter int DEPTH     = 16,
  parameter int SETUP_CYC = 50,
  parameter int GAP_CYC   = 25,
  localparam int LEN_W    = $clog2(DEPTH + 1),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             SS_N,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  output logic [7:0]       err_cnt
);

  localparam int CNT_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [LEN_W-1:0] DEPTH_LEN  = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT_RX,
    GAP,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       tx_buf [DEPTH];
  logic [7:0]       rx_buf [DEPTH];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] start_len;
  logic [AW-1:0]    idx;
  logic [CNT_W-1:0] cnt;
  logic             frame_load;
  logic             idx_inc;
  logic             rx_store;
  logic             last_byte;

  assign start_len = (frame_len > DEPTH_LEN) ? DEPTH_LEN : frame_len;
  assign last_byte = (LEN_W'(idx) == len - LEN_W'(1));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SS_N, byte_valid and done are decoded from state so a reset drops them one cycle later.
  always_comb begin
    state_next = state;
    frame_load = 1'b0;
    idx_inc    = 1'b0;
    rx_store   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    SS_N       = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          frame_load = 1'b1;
          state_next = (start_len == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        SS_N = 1'b0;
        if (cnt == SETUP_LAST) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        SS_N       = 1'b0;
        byte_valid = 1'b1;
        byte_data  = tx_buf[idx];
        if (byte_ready) begin
          state_next = WAIT_RX;
        end
      end
      WAIT_RX: begin
        SS_N = 1'b0;
        if (rx_valid) begin
          rx_store = 1'b1;
          if (last_byte) begin
            state_next = HOLD;
          end else begin
            idx_inc    = 1'b1;
            state_next = (GAP_CYC == 0) ? ISSUE : GAP;
          end
        end
      end
      GAP: begin
        SS_N = 1'b0;
        if (cnt == GAP_LAST) begin
          state_next = ISSUE;
        end
      end
      HOLD: begin
        SS_N = 1'b0;
        if (cnt == SETUP_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The delay counter restarts on every state change and only runs in the timed states.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (state == SETUP || state == GAP || state == HOLD) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      idx <= '0;
      len <= '0;
    end else if (frame_load) begin
      idx <= '0;
      len <= start_len;
    end else if (idx_inc) begin
      idx <= idx + AW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !busy) begin
      tx_buf[wr_addr] <= wr_data;
    end
    if (rx_store) begin
      rx_buf[idx] <= rx_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= rx_buf[rd_addr];
    end
  end

`ifdef SPI_SEQ_ECHO_CHECK_EN
  // The slave echoes the previous byte, so byte idx is compared against tx_buf[idx-1].
  logic echo_miss;

  assign echo_miss = rx_store && (idx != '0) && (rx_data != tx_buf[idx - AW'(1)]);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      err_cnt <= 8'h00;
    end else if (frame_load) begin
      err_cnt <= 8'h00;
    end else if (echo_miss && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: randomized frames, a behavioural SPI engine and queue-based checking.
module tb_spi_frame_sequencer;

  localparam int DEPTH     = 16;
  localparam int SETUP_CYC = 50;
  localparam int GAP_CYC   = 25;
  localparam int LEN_W     = $clog2(DEPTH + 1);
  localparam int AW        = $clog2(DEPTH);

  logic             CLOCK_50;
  logic             RESET;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_data;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             SS_N;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;
  logic [7:0]       err_cnt;

  typedef struct {
    int unsigned due;
    int          idx;
    logic [7:0]  exp;
  } rd_chk_t;

  typedef struct {
    logic [7:0] err;
    int         ss_falls;
  } done_exp_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          done_seen = 0;
  int          last_run = 0;
  bit          stall_mode = 1'b0;

  logic [7:0] exp_tx_q [$];
  logic [7:0] rx_plan_q [$];
  done_exp_t  done_q [$];
  rd_chk_t    rd_q [$];
  logic [7:0] tx_model [DEPTH];
  logic [7:0] rx_model [DEPTH];

  spi_frame_sequencer #(
    .DEPTH    (DEPTH),
    .SETUP_CYC(SETUP_CYC),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .start     (start),
    .frame_len (frame_len),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .SS_N      (SS_N),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .err_cnt   (err_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got unexpected/missing event, required the scheduled one", name);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference: echo errors are the count of positions i>=1 whose RX byte differs from TX byte i-1.
  function automatic int exp_err(input int n);
    int c;
    c = 0;
`ifdef SPI_SEQ_ECHO_CHECK_EN
    for (int i = 1; i < n; i++) begin
      if (rx_model[i] != tx_model[i-1] && c < 255) c++;
    end
`endif
    return c;
  endfunction

  task automatic load_tx();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = tx_model[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic new_tx();
    for (int i = 0; i < DEPTH; i++) tx_model[i] = 8'($urandom);
    load_tx();
  endtask

  task automatic plan_echo_rx();
    rx_model[0] = 8'($urandom);
    for (int i = 1; i < DEPTH; i++) begin
      rx_model[i] = ($urandom_range(0, 3) != 0) ? tx_model[i-1] : 8'($urandom);
    end
  endtask

  // mode: 0 plain, 1 seven-cycle stall on first byte, 2 start/wr_en mid-frame, 3 reset mid-frame
  task automatic apply_stimulus(input int n_req, input int mode);
    int        n;
    int        lat;
    int        d0;
    int        guard;
    done_exp_t e;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    for (int i = 0; i < n; i++) begin
      exp_tx_q.push_back(tx_model[i]);
      rx_plan_q.push_back(rx_model[i]);
    end
    e.err      = 8'(exp_err(n));
    e.ss_falls = (n > 0) ? 1 : 0;
    done_q.push_back(e);
    stall_mode = (mode == 1);
    d0         = done_seen;
    start      = 1'b1;
    frame_len  = LEN_W'(n_req);
    tick();
    start = 1'b0;
    if (n == 0) begin
      check_output("len0_done", done, 1);
      check_output("len0_ss_n", SS_N, 1);
      check_output("len0_valid", byte_valid, 0);
    end else begin
      lat = 1;
      while (!byte_valid && lat < SETUP_CYC + 20) begin
        tick();
        lat++;
      end
      check_output("first_valid_latency", lat, SETUP_CYC + 1);
      if (mode == 2 && n >= 2) begin
        start     = 1'b1;
        frame_len = LEN_W'(1);
        wr_en     = 1'b1;
        wr_addr   = AW'(n - 1);
        wr_data   = ~tx_model[n-1];
        tick();
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (mode == 3) begin
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        check_output("rst_ss_n", SS_N, 1);
        check_output("rst_valid", byte_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_err_cnt", err_cnt, 0);
        tick();
        RESET      = 1'b0;
        stall_mode = 1'b0;
        tick();
        return;
      end
    end
    guard = 0;
    while (done_seen == d0 && guard < 4000) begin
      tick();
      guard++;
    end
    if (done_seen == d0) fail_event("done_timeout");
    stall_mode = 1'b0;
    tick();
    check_output("idle_after_done", busy, 0);
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      rd_q.push_back('{due: cyc + 1, idx: i, exp: rx_model[i]});
      tick();
    end
    repeat (2) tick();
    if (mode == 1) check_output("stall_accept_cycle", last_run, 8);
  endtask

  // Behavioural SPI engine: random or scripted backpressure, replies with the planned MISO byte.
  initial begin : engine
    int         k;
    int         rx_wait;
    bit         hs;
    bit         vis;
    bit         rst;
    bit         pending;
    logic [7:0] pend_data;
    k          = 0;
    rx_wait    = 0;
    pending    = 1'b0;
    pend_data  = 8'h00;
    byte_ready = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    forever begin
      @(negedge CLOCK_50);
      hs  = byte_valid && byte_ready && !RESET;
      vis = byte_valid && !RESET;
      rst = RESET;
      if (vis && !hs) k++;
      else k = 0;
      @(posedge CLOCK_50);
      #1;
      rx_valid = 1'b0;
      if (rst) begin
        pending    = 1'b0;
        byte_ready = 1'b0;
        k          = 0;
        rx_plan_q.delete();
      end else begin
        if (pending) begin
          if (rx_wait == 0) begin
            rx_valid = 1'b1;
            rx_data  = pend_data;
            pending  = 1'b0;
          end else begin
            rx_wait--;
          end
        end
        if (hs) begin
          pending   = 1'b1;
          rx_wait   = $urandom_range(0, 4);
          pend_data = 8'h00;
          if (rx_plan_q.size() > 0) pend_data = rx_plan_q.pop_front();
        end
        byte_ready = stall_mode ? (k >= 7) : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares every handshake, frame end and RX read against the scoreboard queues.
  initial begin : monitor
    bit         prev_stall;
    bit         prev_ss;
    bit         prev_done;
    logic [7:0] prev_data;
    int         run;
    int         ss_falls;
    done_exp_t  e;
    rd_chk_t    r;
    prev_stall = 1'b0;
    prev_ss    = 1'b1;
    prev_done  = 1'b0;
    prev_data  = 8'h00;
    run        = 0;
    ss_falls   = 0;
    forever begin
      @(negedge CLOCK_50);
      if (RESET) begin
        exp_tx_q.delete();
        done_q.delete();
        prev_stall = 1'b0;
        prev_ss    = 1'b1;
        prev_done  = 1'b0;
        run        = 0;
        ss_falls   = 0;
        continue;
      end
      if (prev_stall) begin
        check_output("hold_valid", byte_valid, 1);
        check_output("hold_data", byte_data, prev_data);
      end
      if (byte_valid) check_output("ss_n_during_byte", SS_N, 0);
      if (prev_ss && !SS_N) ss_falls++;
      if (byte_valid) run++;
      else run = 0;
      if (byte_valid && byte_ready) begin
        last_run = run;
        run      = 0;
        if (exp_tx_q.size() == 0) fail_event("extra_byte");
        else check_output("byte_data", byte_data, exp_tx_q.pop_front());
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data  = byte_data;
      if (done) begin
        check_output("done_width", prev_done, 0);
        if (done_q.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          e = done_q.pop_front();
          check_output("err_cnt", err_cnt, e.err);
          check_output("ss_frames", ss_falls, e.ss_falls);
          check_output("bytes_left", exp_tx_q.size(), 0);
          check_output("ss_n_at_done", SS_N, 1);
        end
        ss_falls = 0;
        done_seen++;
      end
      prev_done = done;
      prev_ss   = SS_N;
      while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r = rd_q.pop_front();
        check_output($sformatf("rd_data[%0d]", r.idx), rd_data, r.exp);
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    RESET     = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = 8'h00;
    rd_addr   = '0;
    repeat (3) tick();
    check_output("reset_ss_n", SS_N, 1);
    check_output("reset_valid", byte_valid, 0);
    check_output("reset_byte_data", byte_data, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_rd_data", rd_data, 0);
    check_output("reset_err_cnt", err_cnt, 0);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) tx_model[i] = 8'($urandom);
    tx_model[0] = 8'h55;
    tx_model[1] = 8'hAA;
    tx_model[2] = 8'h0F;
    load_tx();
    rx_model[0] = 8'h00;
    rx_model[1] = 8'h55;
    rx_model[2] = 8'hAA;
    apply_stimulus(3, 0);

    rx_model[2] = 8'hFF;
    apply_stimulus(3, 0);

    apply_stimulus(0, 0);

    new_tx();
    plan_echo_rx();
    apply_stimulus(1, 1);

    new_tx();
    plan_echo_rx();
    apply_stimulus(20, 2);

    plan_echo_rx();
    apply_stimulus(4, 3);
    apply_stimulus(5, 0);

    for (int f = 0; f < 6; f++) begin
      new_tx();
      plan_echo_rx();
      apply_stimulus($urandom_range(0, 20), ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
